// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param. The master drives write/read
// requests and flush; the slave (the FIFO) returns data, occupancy and flags.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);

  logic              flush;
  logic              wr;
  logic [DATA_W-1:0] din;
  logic              rd;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [AW:0]       count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr, din, rd,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr, din, rd,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with power-of-two depth, registered read data, occupancy
// count, programmable almost flags, synchronous flush and sticky error flags.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sync_fifo_param_if.slave     bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW:0]       wp, rp;
  logic [AW:0]       occ;
  logic [DATA_W-1:0] dout_p1;
  logic              vld_p1;
  logic              ovf_q, unf_q;

  logic              full_w, empty_w;
  logic              rd_ok, wr_ok;

  // Extra pointer bit makes wp - rp the exact occupancy, 0..DEPTH, with no wrap
  // special cases; the count therefore moves on the same edge as the pointers.
  assign occ     = wp - rp;
  assign full_w  = (occ == DEPTH_C);
  assign empty_w = (occ == '0);

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_ok = bus.rd & ~empty_w;
  assign wr_ok = bus.wr & (~full_w | rd_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (bus.flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok && !bus.flush) mem[wp[AW-1:0]] <= bus.din;
  end

  // ---- read stage: popped word registered onto dout ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (bus.flush) begin
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= rd_ok;
      if (rd_ok) dout_p1 <= mem[rp[AW-1:0]];
    end
  end

  // Sticky error flags; flush-cycle requests are discarded without flagging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bus.flush) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.wr && !wr_ok) ovf_q <= 1'b1;
      if (bus.rd && !rd_ok) unf_q <= 1'b1;
    end
  end

  assign bus.dout         = dout_p1;
  assign bus.dout_valid   = vld_p1;
  assign bus.count        = occ;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (occ >= AF_C);
  assign bus.almost_empty = (occ <= AE_C);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised self-checking bench for sync_fifo_param against a queue-based
// model of the FIFO rules.
module tb_sync_fifo_param;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AFL    = DEPTH - 2;
  localparam int AEL    = 2;
  localparam logic [11:0] RST_ST = 12'h028;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_vld, m_ovf, m_unf;

  function automatic logic [11:0] exp_st();
    int n;
    n = q.size();
    return {5'(n), n == DEPTH, n == 0, n >= AFL, n <= AEL, m_ovf, m_unf, m_vld};
  endfunction

  function automatic logic [11:0] act_st();
    return {bus.count, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
            bus.overflow, bus.underflow, bus.dout_valid};
  endfunction

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_vld = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f);
    logic rok, wok;
    @(negedge clk);
    bus.wr = w; bus.din = d; bus.rd = r; bus.flush = f;
    @(posedge clk);
    if (f) begin
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_vld = 1'b0;
    end else begin
      rok = r && (q.size() > 0);
      wok = w && ((q.size() < DEPTH) || rok);
      m_vld = rok;
      if (rok) m_dout = q.pop_front();
      if (wok) q.push_back(d);
      if (w && !wok) m_ovf = 1'b1;
      if (r && !rok) m_unf = 1'b1;
    end
    #1;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act_st() !== RST_ST || bus.dout !== 8'h00) begin
      failures++;
      $display("FAIL reset status=%h need=%h dout=%h need=00", act_st(), RST_ST, bus.dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      checks++;
      if (act_st() !== exp_st() || bus.almost_full !== (i + 1 >= AFL) ||
          bus.full !== (i + 1 == DEPTH) || bus.empty !== 1'b0) begin
        failures++;
        $display("FAIL fill[%0d] status=%h need=%h", i, act_st(), exp_st());
      end
    end
  endtask

  task automatic test_overflow();
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    checks++;
    if (bus.overflow !== 1'b1 || bus.count !== 5'd16 || act_st() !== exp_st()) begin
      failures++;
      $display("FAIL overflow status=%h need=%h", act_st(), exp_st());
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky got=%b need=1", bus.overflow);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (act_st() !== exp_st() || bus.dout !== 8'(i) || bus.dout_valid !== 1'b1 ||
          bus.almost_empty !== (DEPTH - 1 - i <= AEL)) begin
        failures++;
        $display("FAIL drain[%0d] status=%h need=%h dout=%h need=%h",
                 i, act_st(), exp_st(), bus.dout, 8'(i));
      end
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (bus.underflow !== 1'b1 || bus.dout_valid !== 1'b0 || bus.dout !== 8'h0F ||
        bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL underflow status=%h dout=%h need unf=1 vld=0 dout=0f", act_st(), bus.dout);
    end
  endtask

  task automatic test_wrap();
    int n [4] = '{10, 10, 12, 12};
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < n[p]; i++) begin
        cyc(p % 2 == 0, 8'($urandom), p % 2 == 1, 1'b0);
        checks++;
        if (act_st() !== exp_st() || bus.dout !== m_dout) begin
          failures++;
          $display("FAIL wrap[%0d.%0d] status=%h need=%h dout=%h need=%h",
                   p, i, act_st(), exp_st(), bus.dout, m_dout);
        end
      end
    end
    checks++;
    if (bus.count !== 5'd0) begin
      failures++;
      $display("FAIL wrap_end count=%0d need=0", bus.count);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'($urandom), 1'b1, 1'b0);
      checks++;
      if (act_st() !== exp_st() || bus.count !== 5'd16 || bus.overflow !== 1'b0 ||
          bus.dout !== m_dout) begin
        failures++;
        $display("FAIL rw_full[%0d] status=%h need=%h dout=%h need=%h",
                 i, act_st(), exp_st(), bus.dout, m_dout);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (act_st() !== exp_st() || bus.dout !== m_dout) begin
        failures++;
        $display("FAIL rw_drain[%0d] status=%h need=%h dout=%h need=%h",
                 i, act_st(), exp_st(), bus.dout, m_dout);
      end
    end
    cyc(1'b1, 8'h5C, 1'b1, 1'b0);
    checks++;
    if (bus.count !== 5'd1 || bus.underflow !== 1'b1 || bus.dout_valid !== 1'b0 ||
        act_st() !== exp_st()) begin
      failures++;
      $display("FAIL rw_empty status=%h need=%h", act_st(), exp_st());
    end
  endtask

  task automatic test_flush();
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (bus.count !== 5'd5 || bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL pre_flush count=%0d ovf=%b need 5/1", bus.count, bus.overflow);
    end
    cyc(1'b1, 8'hEE, 1'b0, 1'b1);
    checks++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.overflow !== 1'b0 ||
        bus.dout !== m_dout || act_st() !== exp_st()) begin
      failures++;
      $display("FAIL flush status=%h need=%h dout=%h need=%h",
               act_st(), exp_st(), bus.dout, m_dout);
    end
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (bus.dout !== 8'h77 || bus.dout_valid !== 1'b1 || bus.count !== 5'd0) begin
      failures++;
      $display("FAIL flush_discard dout=%h vld=%b need 77/1", bus.dout, bus.dout_valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'($urandom), i > 2, 1'b0);
    @(negedge clk);
    bus.wr = 1'b1; bus.din = 8'h99;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (act_st() !== RST_ST || bus.dout !== 8'h00) begin
      failures++;
      $display("FAIL async_reset status=%h need=%h dout=%h", act_st(), RST_ST, bus.dout);
    end
    @(posedge clk);
    #1;
    checks++;
    if (act_st() !== RST_ST) begin
      failures++;
      $display("FAIL reset_hold status=%h need=%h", act_st(), RST_ST);
    end
    @(negedge clk);
    bus.wr = 1'b0;
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (act_st() !== RST_ST) begin
      failures++;
      $display("FAIL post_reset status=%h need=%h", act_st(), RST_ST);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 5,
          $urandom_range(0, 63) == 0);
      checks++;
      if (act_st() !== exp_st() || bus.dout !== m_dout) begin
        failures++;
        $display("FAIL random[%0d] status=%h need=%h dout=%h need=%h",
                 i, act_st(), exp_st(), bus.dout, m_dout);
      end
    end
  endtask

  initial begin
    bus.wr = 1'b0; bus.rd = 1'b0; bus.flush = 1'b0; bus.din = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO: generalised width and power-of-two depth. Adds an occupancy count, programmable almost-full/almost-empty flags, read-data valid, synchronous flush, and sticky overflow/underflow error flags. Standard buffering element between datapath stages in one clock domain. Read data is registered (1-cycle read latency).

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
AW, log2(DEPTH), address width; derived, not overridden
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of FIFO contents and flags
wr  in  1  write request
din  in  DATA_W  write data
rd  in  1  read request
dout  out  DATA_W  read data, registered
dout_valid  out  1  dout holds a word popped on the previous edge
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  AW+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset (rst_n low, async): wp=rp=0, count=0, dout=0, dout_valid=0, overflow=underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=0 (AF_LEVEL>0). Memory contents not reset.
- Pointers wp, rp are AW+1 bits; address = low AW bits; natural wrap at DEPTH, no special-case logic.
- rd_ok = rd & ~empty. wr_ok = wr & (~full | rd_ok): write into a full FIFO is accepted when a read is accepted the same cycle.
- wr_ok: mem[wp[AW-1:0]] <= din; wp <= wp+1.
- rd_ok: dout <= mem[rp[AW-1:0]]; rp <= rp+1; dout_valid <= 1. Otherwise dout holds its value, dout_valid <= 0.
- Read latency: word visible on dout with dout_valid=1 in the cycle after the edge that accepted rd.
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. Never exceeds DEPTH, never wraps below 0.
- full, empty, almost_full, almost_empty: combinational decodes of registered count; update on the same edge as count. No cycle of lag vs. pointers.
- Simultaneous rd & wr when empty: read rejected (underflow set), write accepted; count 0->1; no bypass of din to dout.
- Simultaneous rd & wr when full: both accepted; count stays DEPTH; written word lands in the slot just freed.
- overflow <= 1 when wr & ~wr_ok; underflow <= 1 when rd & ~rd_ok. Both sticky; cleared only by reset or flush.
- flush (priority over wr/rd the same cycle): wp=rp=0, count=0, overflow=underflow=0, dout_valid=0; dout holds value. Requests in the flush cycle are discarded and not flagged.
- Reset mid-operation: immediate return to reset state; no partial writes after rst_n deasserts.
- No combinational path from wr/rd/din to any output.

Test Plan:
1. Reset, then 16 writes of 0x00..0x0F with no reads -> count 1..16; almost_full at count 14; full at 16; overflow=0; empty deasserts after the first edge.
2. From full, write 0xAA with no read -> overflow=1 and stays 1; count=16; 0xAA never read out.
3. From full, 16 reads -> dout 0x00..0x0F in order, each with dout_valid one cycle after rd; almost_empty at count 2; empty at 0; a 17th read sets underflow, dout_valid=0, dout holds 0x0F.
4. Wrap: write 10, read 10, write 12, read 12 -> data order preserved across the pointer wrap at 16; count returns to 0.
5. Simultaneous rd & wr at count=16 and at count=0 -> full case: count stays 16, data order intact, no overflow. Empty case: count becomes 1, underflow=1, dout_valid=0.
6. At count=5 with overflow=1, assert flush together with wr -> next cycle count=0, empty=1, overflow=0, write discarded. Then assert rst_n low mid-burst -> all outputs reach reset values asynchronously.
